mesi_line_ctrl: RTL and testbench

Sequential controller for the L2 MESI coherence state of a small set of cache lines, in front of the system bus. Accepts one trace command at a time from the L2 front end using a valid/ready handshake. Holds the per-line MESI state array and issues bus operations (READ, RFO, INVALIDATE, WRITEBACK) through a second handshake. Writes the resulting state back and reports it, together with the snoop result it returns on behalf of this cache.

---
 rtl/mesi_line_ctrl_if.sv | 37 +++
 rtl/mesi_line_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_mesi_line_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_line_ctrl_if.sv
// mesi_line_ctrl_if: command, bus and completion signals of the MESI line controller.
// slave is the controller side; master is the front end / bus / bench side.
interface mesi_line_ctrl_if #(
  parameter int unsigned IDX_W = 4
) ();
  // Command handshake from the L2 front end
  logic             reqValid;
  logic             reqReady;
  logic [3:0]       reqCmd;
  logic [IDX_W-1:0] reqIdx;

  // System bus handshake
  logic             busValid;
  logic             busReady;
  logic [1:0]       busOp;
  logic [IDX_W-1:0] busIdx;
  logic [1:0]       snoopResp;

  // Completion report
  logic             doneValid;
  logic [1:0]       doneState;
  logic [IDX_W-1:0] doneIdx;
  logic [1:0]       snoopResult;
  logic             errCmd;

  modport slave (
    input  reqValid, reqCmd, reqIdx, busReady, snoopResp,
    output reqReady, busValid, busOp, busIdx,
           doneValid, doneState, doneIdx, snoopResult, errCmd
  );

  modport master (
    output reqValid, reqCmd, reqIdx, busReady, snoopResp,
    input  reqReady, busValid, busOp, busIdx,
           doneValid, doneState, doneIdx, snoopResult, errCmd
  );
endinterface

// File: rtl/mesi_line_ctrl.sv
// mesi_line_ctrl: per-line MESI state array with a one-command-at-a-time sequencer that
// issues READ / RFO / INVALIDATE / WRITEBACK bus operations and reports the resulting state.
// Optional build macro MESI_STATS_EN adds saturating hit/miss/writeback counters.
module mesi_line_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  mesi_line_ctrl_if.slave link
);

  typedef enum logic [2:0] {StIdle, StLookup, StBus, StUpdate, StClear} fsm_e;

  localparam logic [1:0] LsM = 2'b00;
  localparam logic [1:0] LsE = 2'b01;
  localparam logic [1:0] LsS = 2'b10;
  localparam logic [1:0] LsI = 2'b11;

  localparam logic [1:0] OpRead = 2'b00;
  localparam logic [1:0] OpRfo  = 2'b01;
  localparam logic [1:0] OpWb   = 2'b10;
  localparam logic [1:0] OpInv  = 2'b11;

  localparam logic [1:0] SrNoHit = 2'b00;
  localparam logic [1:0] SrHit   = 2'b01;
  localparam logic [1:0] SrHitm  = 2'b10;

  localparam logic [3:0] CmdRead     = 4'd0;
  localparam logic [3:0] CmdWrite    = 4'd1;
  localparam logic [3:0] CmdInstRead = 4'd2;
  localparam logic [3:0] CmdSnpInv   = 4'd3;
  localparam logic [3:0] CmdSnpRead  = 4'd4;
  localparam logic [3:0] CmdSnpWrite = 4'd5;
  localparam logic [3:0] CmdSnpRfo   = 4'd6;
  localparam logic [3:0] CmdClear    = 4'd8;

  fsm_e             stQ, stD;
  logic [3:0]       cmdQ;
  logic [IDX_W-1:0] idxQ;
  logic [IDX_W-1:0] clrCntQ;
  logic [1:0]       lineArr [LINES];
  logic [1:0]       nxtLineQ;
  logic [1:0]       snoopResQ;
  logic [1:0]       busOpQ;
  logic             errQ;

  logic [1:0]       curLine;
  logic [1:0]       lkNxt;
  logic [1:0]       lkSnoop;
  logic [1:0]       lkOp;
  logic             lkNeedBus;
  logic             lkErr;
  logic             reqFire;
  logic             busFire;
  logic             clrLast;

  assign reqFire = link.reqValid & link.reqReady;
  assign busFire = (stQ == StBus) & link.busReady;
  assign clrLast = (clrCntQ == IDX_W'(LINES - 1));

  // Ready is masked by rst_n so nothing is accepted while reset is held.
  assign link.reqReady    = (stQ == StIdle) & rst_n;
  assign link.busValid    = (stQ == StBus);
  assign link.busOp       = busOpQ;
  assign link.busIdx      = idxQ;
  assign link.doneValid   = (stQ == StUpdate);
  assign link.doneState   = nxtLineQ;
  assign link.doneIdx     = idxQ;
  assign link.snoopResult = snoopResQ;
  assign link.errCmd      = (stQ == StUpdate) & errQ;

  // Transition decision for the addressed line; read misses pick E here and are refined
  // from snoopResp on the bus handshake.
  always_comb begin
    curLine   = lineArr[idxQ];
    lkNxt     = curLine;
    lkSnoop   = SrNoHit;
    lkOp      = OpRead;
    lkNeedBus = 1'b0;
    lkErr     = 1'b0;
    case (cmdQ)
      CmdRead, CmdInstRead: begin
        if (curLine == LsI) begin
          lkNeedBus = 1'b1;
          lkOp      = OpRead;
          lkNxt     = LsE;
        end
      end
      CmdWrite: begin
        lkNxt = LsM;
        if (curLine == LsS) begin
          lkNeedBus = 1'b1;
          lkOp      = OpInv;
        end else if (curLine == LsI) begin
          lkNeedBus = 1'b1;
          lkOp      = OpRfo;
        end
      end
      CmdSnpInv: begin
        if (curLine == LsS) lkNxt = LsI;
      end
      CmdSnpRead: begin
        if (curLine == LsM) begin
          lkNxt     = LsS;
          lkSnoop   = SrHitm;
          lkNeedBus = 1'b1;
          lkOp      = OpWb;
        end else if (curLine != LsI) begin
          lkNxt   = LsS;
          lkSnoop = SrHit;
        end
      end
      CmdSnpWrite: begin
      end
      CmdSnpRfo: begin
        if (curLine == LsM) begin
          lkNxt     = LsI;
          lkSnoop   = SrHitm;
          lkNeedBus = 1'b1;
          lkOp      = OpWb;
        end else if (curLine != LsI) begin
          lkNxt   = LsI;
          lkSnoop = SrHit;
        end
      end
      CmdClear: begin
      end
      default: lkErr = 1'b1;
    endcase
  end

  // FSM next-state
  always_comb begin
    stD = stQ;
    unique case (stQ)
      StIdle: begin
        if (reqFire) stD = (link.reqCmd == CmdClear) ? StClear : StLookup;
      end
      StLookup: stD = lkNeedBus ? StBus : StUpdate;
      StBus:    if (link.busReady) stD = StUpdate;
      StUpdate: stD = StIdle;
      StClear:  if (clrLast) stD = StUpdate;
      default:  stD = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stQ <= StIdle;
    else        stQ <= stD;
  end

  // Command capture, lookup results, bus-op latch and state array writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdQ      <= 4'd0;
      idxQ      <= '0;
      clrCntQ   <= '0;
      nxtLineQ  <= LsI;
      snoopResQ <= SrNoHit;
      busOpQ    <= OpRead;
      errQ      <= 1'b0;
      for (int i = 0; i < LINES; i++) lineArr[i] <= LsI;
    end else begin
      unique case (stQ)
        StIdle: begin
          if (reqFire) begin
            cmdQ      <= link.reqCmd;
            errQ      <= 1'b0;
            snoopResQ <= SrNoHit;
            if (link.reqCmd == CmdClear) begin
              idxQ     <= '0;
              clrCntQ  <= '0;
              nxtLineQ <= LsI;
            end else begin
              idxQ <= link.reqIdx;
            end
          end
        end
        StLookup: begin
          nxtLineQ  <= lkNxt;
          snoopResQ <= lkSnoop;
          errQ      <= lkErr;
          if (lkNeedBus) busOpQ <= lkOp;
        end
        StBus: begin
          // 11 from the snoopers is treated like noHIT.
          if (busFire && busOpQ == OpRead) begin
            nxtLineQ <= (link.snoopResp == SrHit || link.snoopResp == SrHitm) ? LsS : LsE;
          end
        end
        StUpdate: lineArr[idxQ] <= nxtLineQ;
        StClear: begin
          lineArr[clrCntQ] <= LsI;
          clrCntQ          <= clrCntQ + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MESI_STATS_EN
  logic [15:0] hitCnt;
  logic [15:0] missCnt;
  logic [15:0] wbCnt;
  logic        l1Cmd;

  assign l1Cmd = (cmdQ == CmdRead) | (cmdQ == CmdWrite) | (cmdQ == CmdInstRead);

  // Saturating statistics: L1 hits at lookup, bus ops counted on their handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCnt  <= 16'd0;
      missCnt <= 16'd0;
      wbCnt   <= 16'd0;
    end else begin
      if (stQ == StLookup && l1Cmd && !lkNeedBus && hitCnt != 16'hFFFF) begin
        hitCnt <= hitCnt + 16'd1;
      end
      if (busFire && (busOpQ == OpRead || busOpQ == OpRfo) && missCnt != 16'hFFFF) begin
        missCnt <= missCnt + 16'd1;
      end
      if (busFire && busOpQ == OpWb && wbCnt != 16'hFFFF) begin
        wbCnt <= wbCnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// tb_mesi_line_ctrl: directed scenarios plus randomized commands, checked against a
// behavioural MESI model (state table per line) with cycle-exact handshake timing.
module tb_mesi_line_ctrl;
  localparam int LINES = 16;
  localparam int IDX_W = 4;

  localparam int M = 0, E = 1, S = 2, I = 3;
  localparam int OP_READ = 0, OP_RFO = 1, OP_WB = 2, OP_INV = 3;
  localparam int NOHIT = 0, HIT = 1, HITM = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mesi_line_ctrl_if #(.IDX_W(IDX_W)) link ();

  mesi_line_ctrl #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;
  int model [LINES];
  int hitModel = 0, missModel = 0, wbModel = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < LINES; i++) model[i] = I;
    hitModel = 0;
    missModel = 0;
    wbModel = 0;
  endtask

  // MESI protocol rules for one non-clear command on a line in state cur
  function automatic void predict(input int cmd, input int cur, input int sresp,
                                  output bit need, output int op, output int nxt,
                                  output int snp, output bit err);
    need = 1'b0; op = OP_READ; nxt = cur; snp = NOHIT; err = 1'b0;
    case (cmd)
      0, 2: if (cur == I) begin
        need = 1'b1; op = OP_READ;
        nxt = (sresp == HIT || sresp == HITM) ? S : E;
      end
      1: begin
        nxt = M;
        if (cur == S) begin need = 1'b1; op = OP_INV; end
        else if (cur == I) begin need = 1'b1; op = OP_RFO; end
      end
      3: if (cur == S) nxt = I;
      4: if (cur != I) begin
        nxt = S; snp = (cur == M) ? HITM : HIT; need = (cur == M); op = OP_WB;
      end
      5: ;
      6: if (cur != I) begin
        nxt = I; snp = (cur == M) ? HITM : HIT; need = (cur == M); op = OP_WB;
      end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!link.reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal("req_ready", link.reqReady, 1);
  endtask

  // Issue one command and check every cycle until completion
  task automatic runCmd(input int cmd, input int idx, input int sresp, input int stall);
    bit need, err;
    int op, nxt, snp;
    logic [6:0] expBus;
    waitReady();
    link.reqValid = 1'b1;
    link.reqCmd   = 4'(cmd);
    link.reqIdx   = 4'(idx);
    @(negedge clk);
    link.reqValid = 1'b0;
    link.reqIdx   = 4'($urandom_range(0, 15));
    if (cmd == 8) begin
      int k = 1;
      bit sawBus = 1'b0;
      while (!link.doneValid && k < 4 * LINES) begin
        sawBus |= link.busValid;
        checkVal("clr_not_ready", link.reqReady, 0);
        @(negedge clk);
        k++;
      end
      checkVal("clr_latency", k, LINES + 1);
      checkVal("clr_bus", sawBus, 0);
      checkVal("clr_done", {link.doneState, link.doneIdx, link.errCmd, link.snoopResult},
               {2'b11, 4'h0, 1'b0, 2'b00});
      for (int i = 0; i < LINES; i++) model[i] = I;
    end else begin
      predict(cmd, model[idx], sresp, need, op, nxt, snp, err);
      checkVal("lookup_quiet", {link.busValid, link.doneValid, link.reqReady}, 3'b000);
      @(negedge clk);
      if (need) begin
        expBus = {1'b1, 2'(op), 4'(idx)};
        for (int s = 0; s < stall; s++) begin
          link.snoopResp = 2'($urandom_range(0, 3));
          checkVal("bus_hold", {link.busValid, link.busOp, link.busIdx}, expBus);
          checkVal("bus_no_done", link.doneValid, 0);
          @(negedge clk);
        end
        checkVal("bus_req", {link.busValid, link.busOp, link.busIdx}, expBus);
        link.busReady  = 1'b1;
        link.snoopResp = 2'(sresp);
        @(negedge clk);
        link.busReady  = 1'b0;
        link.snoopResp = 2'($urandom_range(0, 3));
        if (op == OP_READ || op == OP_RFO) missModel++;
        if (op == OP_WB) wbModel++;
      end else if (cmd <= 2 && !err) begin
        hitModel++;
      end
      checkVal("done_valid", {link.doneValid, link.busValid}, 2'b10);
      checkVal("done_state", link.doneState, nxt);
      checkVal("done_idx", link.doneIdx, idx);
      checkVal("snoop_result", link.snoopResult, snp);
      checkVal("err_cmd", link.errCmd, err);
      model[idx] = nxt;
    end
    @(negedge clk);
    checkVal("done_pulse_end", {link.doneValid, link.errCmd, link.reqReady}, 3'b001);
  endtask

  // Pull reset while an RFO waits in BUS
  task automatic resetInBus(input int idx);
    waitReady();
    link.reqValid = 1'b1;
    link.reqCmd   = 4'd1;
    link.reqIdx   = 4'(idx);
    @(negedge clk);
    link.reqValid = 1'b0;
    @(negedge clk);
    checkVal("rst_bus_before", {link.busValid, link.busOp}, 3'b101);
    rst_n = 1'b0;
    #1;
    checkVal("rst_bus_drop", link.busValid, 0);
    checkVal("rst_not_ready", link.reqReady, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    @(negedge clk);
    checkVal("rst_after", {link.busValid, link.reqReady, link.doneValid}, 3'b010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cmd, idx, r;
    link.reqValid  = 1'b0;
    link.reqCmd    = 4'd0;
    link.reqIdx    = '0;
    link.busReady  = 1'b0;
    link.snoopResp = 2'd0;
    resetModel();
    repeat (3) @(negedge clk);
    checkVal("reset_ready", link.reqReady, 0);
    checkVal("reset_outs", {link.busValid, link.doneValid, link.errCmd, link.busOp, link.busIdx,
                            link.doneIdx, link.snoopResult, link.doneState},
             {3'b000, 2'b00, 4'h0, 4'h0, 2'b00, 2'b11});
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("reset_release_ready", link.reqReady, 1);

    runCmd(0, 3, NOHIT, 0);
    runCmd(1, 3, NOHIT, 0);
    runCmd(0, 5, HITM, 0);
    runCmd(4, 5, NOHIT, 0);
    runCmd(0, 7, NOHIT, 0);
    runCmd(1, 7, NOHIT, 0);
    runCmd(6, 7, NOHIT, 2);
    runCmd(1, 9, NOHIT, 10);
    runCmd(0, 11, 3, 1);
    runCmd(9, 3, NOHIT, 0);
    runCmd(0, 3, NOHIT, 0);
    runCmd(8, 0, NOHIT, 0);
    resetInBus(12);
    for (int i = 0; i < LINES; i++) runCmd(0, i, int'($urandom_range(0, 3)), 0);
    runCmd(8, 0, NOHIT, 0);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85) cmd = int'($urandom_range(0, 6));
      else if (r < 96) begin
        cmd = int'($urandom_range(7, 15));
        if (cmd == 8) cmd = 7;
      end else cmd = 8;
      idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, LINES - 1));
      runCmd(cmd, idx, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

`ifdef MESI_STATS_EN
    checkVal("stat_hit", dut.hitCnt, hitModel);
    checkVal("stat_miss", dut.missCnt, missModel);
    checkVal("stat_wb", dut.wbCnt, wbModel);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
